// File: rtl/servant_timer_scheduler.sv
// -----------------------------------------------------------------------------
// servant_timer_scheduler
//   A free-running timebase with CHANNELS one-shot timer channels. Software
//   arms a channel with a relative delay, and the channel expires once the
//   timebase reaches the resulting deadline. A single comparator is shared
//   between all channels: after every timebase tick, a small scanner visits
//   the channels one per clock.
//
// Ports
//   i_clk     sole clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_wb_adr  word address (0 NOW, 1 PENDING, 2 ENABLE, 3 ARMED, 8+n DEADLINE n)
//   i_wb_dat  write data
//   i_wb_we   write strobe, qualified by i_wb_cyc
//   i_wb_cyc  single-cycle bus access valid (no ack)
//   o_wb_rdt  registered read data, updated on read accesses only
//   o_irq     registered level interrupt: any pending & enabled channel
// -----------------------------------------------------------------------------
module servant_timer_scheduler #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 7
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_irq
);

    localparam int PW = $clog2(PRESCALE + 1);
    localparam int CW = $clog2(CHANNELS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE);
    localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    logic [PW-1:0]       presc_r;
    logic [WIDTH-1:0]    now_r;
    logic [WIDTH-1:0]    deadline_r [CHANNELS];
    logic [CHANNELS-1:0] armed_r;
    logic [CHANNELS-1:0] pending_r;
    logic [CHANNELS-1:0] enable_r;
    logic                irq_r;
    logic [31:0]         rdt_r;
    state_t              state_r;
    state_t              state_s;
    logic [CW-1:0]       chan_r;
    logic [CW-1:0]       chan_s;

    logic                tick_s;
    logic                wr_s;
    logic                rd_s;
    logic                now_wr_s;
    logic                pend_wr_s;
    logic                en_wr_s;
    logic [CHANNELS-1:0] arm_s;
    logic [CHANNELS-1:0] expire_s;
    logic [CHANNELS-1:0] w1c_s;
    logic [WIDTH-1:0]    sel_dl_s;
    logic [WIDTH-1:0]    diff_s;
    logic                hit_s;
    logic [31:0]         rdata_s;

    assign tick_s    = (presc_r == PRESC_MAX);
    assign wr_s      = i_wb_cyc & i_wb_we;
    assign rd_s      = i_wb_cyc & ~i_wb_we;
    assign now_wr_s  = wr_s && (i_wb_adr == 4'd0);
    assign pend_wr_s = wr_s && (i_wb_adr == 4'd1);
    assign en_wr_s   = wr_s && (i_wb_adr == 4'd2);
    assign w1c_s     = pend_wr_s ? i_wb_dat[CHANNELS-1:0] : {CHANNELS{1'b0}};

    // Deadline under the scanner plus the wrap-safe "now has reached it" test.
    // The sign bit of (now - deadline) is clear once now is at or past the
    // deadline, as long as delays stay below half the timebase range.
    always_comb begin
        sel_dl_s = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            sel_dl_s = (chan_r == CW'(n)) ? deadline_r[n] : sel_dl_s;
        end
    end

    assign diff_s = now_r - sel_dl_s;
    // A NOW write aborts the scan, so it also suppresses any expiry that cycle.
    assign hit_s  = (state_r == S_SCAN) && !now_wr_s && !diff_s[WIDTH-1];

    // Per-channel arm strobes and expiry events; an arm write to the channel
    // being visited takes precedence over its expiry.
    always_comb begin
        arm_s    = '0;
        expire_s = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            arm_s[n]    = wr_s && i_wb_adr[3] && (i_wb_adr[2:0] == 3'(n));
            expire_s[n] = hit_s && (chan_r == CW'(n)) && armed_r[n] && !arm_s[n];
        end
    end

    // Scanner next-state: start on tick, step one channel per clock, stop
    // after the last channel or when the timebase is rewritten.
    always_comb begin
        state_s = state_r;
        chan_s  = chan_r;
        case (state_r)
            S_IDLE: begin
                if (tick_s && !now_wr_s) begin
                    state_s = S_SCAN;
                    chan_s  = '0;
                end else begin
                    state_s = S_IDLE;
                    chan_s  = '0;
                end
            end
            S_SCAN: begin
                if (now_wr_s || (chan_r == LAST_CH)) begin
                    state_s = S_IDLE;
                    chan_s  = '0;
                end else begin
                    state_s = S_SCAN;
                    chan_s  = chan_r + 1'b1;
                end
            end
            default: begin
                state_s = S_IDLE;
                chan_s  = '0;
            end
        endcase
    end

    // Read data selection; unmapped addresses and bits return zero.
    always_comb begin
        rdata_s = '0;
        if (i_wb_adr[3]) begin
            for (int n = 0; n < CHANNELS; n++) begin
                rdata_s[WIDTH-1:0] = (i_wb_adr[2:0] == 3'(n)) ? deadline_r[n] : rdata_s[WIDTH-1:0];
            end
        end else begin
            case (i_wb_adr[2:0])
                3'd0:    rdata_s[WIDTH-1:0]    = now_r;
                3'd1:    rdata_s[CHANNELS-1:0] = pending_r;
                3'd2:    rdata_s[CHANNELS-1:0] = enable_r;
                3'd3:    rdata_s[CHANNELS-1:0] = armed_r;
                default: rdata_s = '0;
            endcase
        end
    end

    // Scanner state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= S_IDLE;
            chan_r  <= '0;
        end else begin
            state_r <= state_s;
            chan_r  <= chan_s;
        end
    end

    // Prescaler and timebase; a NOW write restarts both from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_r <= '0;
            now_r   <= '0;
        end else if (now_wr_s) begin
            presc_r <= '0;
            now_r   <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
            now_r   <= now_r + 1'b1;
        end else begin
            presc_r <= presc_r + 1'b1;
        end
    end

    // Deadline storage: absolute deadline computed at arm time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < CHANNELS; n++) begin
                deadline_r[n] <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (arm_s[n]) begin
                    deadline_r[n] <= now_r + i_wb_dat[WIDTH-1:0];
                end
            end
        end
    end

    // Channel status. Expiry is ORed in after the W1C so that a clear landing
    // on the expiry cycle cannot lose the event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed_r   <= '0;
            pending_r <= '0;
            enable_r  <= '0;
        end else begin
            armed_r   <= (armed_r & ~expire_s) | arm_s;
            pending_r <= (pending_r & ~w1c_s & ~arm_s) | expire_s;
            if (en_wr_s) begin
                enable_r <= i_wb_dat[CHANNELS-1:0];
            end
        end
    end

    // Registered interrupt and read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_r <= 1'b0;
            rdt_r <= '0;
        end else begin
            irq_r <= |(pending_r & enable_r);
            if (rd_s) begin
                rdt_r <= rdata_s;
            end
        end
    end

    assign o_irq    = irq_r;
    assign o_wb_rdt = rdt_r;

endmodule

// File: tb/tb_servant_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_servant_timer_scheduler
//   Directed bench for servant_timer_scheduler. Bus accesses are driven and
//   sampled on the falling clock edge, one access per clock. Each scenario
//   restarts the timebase with a NOW write so that tick and scan cycles are
//   known exactly: after the NOW write at edge P0, now becomes k at edge P(8k)
//   and channel c is visited in the cycle ending at edge P(8k+c+1).
//   An 8-bit timebase keeps the wrap-around run short.
// -----------------------------------------------------------------------------
module tb_servant_timer_scheduler;

    logic        i_clk;
    logic        i_rst_n;
    logic [3:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_irq;

    int          n_checks;
    int          n_fail;
    logic [31:0] rdata;

    servant_timer_scheduler #(
        .WIDTH    (8),
        .CHANNELS (4),
        .PRESCALE (7)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .o_wb_rdt (o_wb_rdt),
        .o_irq    (o_irq)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_wr(input logic [3:0] a, input logic [31:0] d);
        i_wb_cyc = 1'b1;
        i_wb_we  = 1'b1;
        i_wb_adr = a;
        i_wb_dat = d;
        @(negedge i_clk);
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        i_wb_dat = 32'h0;
    endtask

    task automatic wb_rd(input logic [3:0] a, output logic [31:0] d);
        i_wb_cyc = 1'b1;
        i_wb_we  = 1'b0;
        i_wb_adr = a;
        @(negedge i_clk);
        d = o_wb_rdt;
        i_wb_cyc = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_rd(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_fail   = 0;
        i_rst_n  = 1'b0;
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        i_wb_adr = 4'h0;
        i_wb_dat = 32'h0;
        rdata    = 32'h0;

        // Reset state.
        idle(3);
        check_eq("rst_rdt", o_wb_rdt, 32'h0);
        check_eq("rst_irq", {31'h0, o_irq}, 32'h0);
        i_rst_n = 1'b1;
        rd_chk("rst_now",      4'd0,  32'h0);
        rd_chk("rst_enable",   4'd2,  32'h0);
        rd_chk("rst_armed",    4'd3,  32'h0);
        rd_chk("rst_pending",  4'd1,  32'h0);
        rd_chk("rst_dl0",      4'd8,  32'h0);
        rd_chk("unmapped_4",   4'd4,  32'h0);
        rd_chk("unmapped_12",  4'd12, 32'h0);
        // First tick lands 8 clocks after release.
        rd_chk("first_tick_before", 4'd0, 32'h0);
        rd_chk("first_tick_after",  4'd0, 32'h1);

        // Basic one-shot: ENABLE=1, DEADLINE0=3.
        wb_wr(4'd0, 32'h0);
        wb_wr(4'd2, 32'h1);
        wb_wr(4'd8, 32'h3);
        rd_chk("basic_dl0",   4'd8, 32'h3);
        rd_chk("basic_armed", 4'd3, 32'h1);
        check_eq("basic_irq_low", {31'h0, o_irq}, 32'h0);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge i_clk);
            if (o_irq) lat = k;
        end
        check_eq("basic_irq_latency", lat, 32'd22);
        rd_chk("basic_pending", 4'd1, 32'h1);
        rd_chk("basic_disarm",  4'd3, 32'h0);
        wb_wr(4'd1, 32'h1);

        // Wrap: arm ch3 delay 4 at now=0xFE -> deadline 0x02.
        wb_wr(4'd0, 32'h0);
        idle(2032);
        wb_wr(4'd11, 32'h4);
        rd_chk("wrap_dl3", 4'd11, 32'h2);
        idle(32);
        rd_chk("wrap_pend_early", 4'd1, 32'h0);
        rd_chk("wrap_pend_edge",  4'd1, 32'h0);
        rd_chk("wrap_pend_fired", 4'd1, 32'h8);
        check_eq("wrap_irq_masked", {31'h0, o_irq}, 32'h0);
        wb_wr(4'd1, 32'h8);

        // Ordering and masking: ch1 delay 5, ch2 delay 2, ENABLE=0x2.
        wb_wr(4'd0, 32'h0);
        wb_wr(4'd2, 32'h2);
        wb_wr(4'd9, 32'h5);
        wb_wr(4'd10, 32'h2);
        idle(16);
        rd_chk("order_pend_ch2", 4'd1, 32'h4);
        check_eq("order_irq_masked", {31'h0, o_irq}, 32'h0);
        idle(22);
        check_eq("order_irq_pre", {31'h0, o_irq}, 32'h0);
        idle(1);
        check_eq("order_irq_ch1", {31'h0, o_irq}, 32'h1);
        rd_chk("order_pend_both", 4'd1, 32'h6);
        wb_wr(4'd1, 32'h6);

        // W1C racing expiry; delay 0 fires in the first scan.
        wb_wr(4'd0, 32'h0);
        wb_wr(4'd2, 32'h1);
        wb_wr(4'd8, 32'h0);
        idle(6);
        wb_wr(4'd1, 32'h1);
        rd_chk("w1c_race_pend", 4'd1, 32'h1);
        check_eq("w1c_race_irq", {31'h0, o_irq}, 32'h1);
        wb_wr(4'd1, 32'h1);
        check_eq("w1c_irq_hold", {31'h0, o_irq}, 32'h1);
        idle(1);
        check_eq("w1c_irq_drop", {31'h0, o_irq}, 32'h0);
        rd_chk("w1c_pend_clear", 4'd1, 32'h0);

        // Rewrite DEADLINE0 on its visit cycle.
        wb_wr(4'd0, 32'h0);
        wb_wr(4'd8, 32'h0);
        idle(7);
        wb_wr(4'd8, 32'h3);
        rd_chk("rearm_no_expiry", 4'd1, 32'h0);
        rd_chk("rearm_armed",     4'd3, 32'h1);
        rd_chk("rearm_dl0",       4'd8, 32'h4);
        idle(20);
        rd_chk("rearm_pend_edge",  4'd1, 32'h0);
        rd_chk("rearm_pend_fired", 4'd1, 32'h1);
        wb_wr(4'd1, 32'h1);

        // NOW write aborts the scan on ch1's visit.
        wb_wr(4'd0, 32'h0);
        wb_wr(4'd9, 32'h0);
        idle(8);
        wb_wr(4'd0, 32'h0);
        rd_chk("abort_no_expiry", 4'd1, 32'h0);
        rd_chk("abort_armed",     4'd3, 32'h2);
        idle(8);
        rd_chk("abort_next_scan", 4'd1, 32'h2);
        wb_wr(4'd1, 32'h2);

        // Reset pulse mid-scan with three channels armed.
        wb_wr(4'd0, 32'h0);
        wb_wr(4'd8, 32'h2);
        wb_wr(4'd9, 32'h2);
        wb_wr(4'd10, 32'h2);
        wb_wr(4'd2, 32'h7);
        rd_chk("midrst_dl0",   4'd8, 32'h2);
        rd_chk("midrst_armed", 4'd3, 32'h7);
        idle(3);
        i_rst_n = 1'b0;
        #1;
        check_eq("midrst_async_rdt", o_wb_rdt, 32'h0);
        check_eq("midrst_async_irq", {31'h0, o_irq}, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        rd_chk("midrst_armed0",  4'd3,  32'h0);
        rd_chk("midrst_pending", 4'd1,  32'h0);
        rd_chk("midrst_enable",  4'd2,  32'h0);
        rd_chk("midrst_dl0_clr", 4'd8,  32'h0);
        rd_chk("midrst_dl2_clr", 4'd10, 32'h0);
        idle(40);
        rd_chk("midrst_no_pend", 4'd1, 32'h0);
        check_eq("midrst_no_irq", {31'h0, o_irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
